// File: rtl/mac_array.sv
// mac_array: weight-stationary systolic MAC array of MAC_ROW x MAC_COL processing elements.
//
// Weights are shifted down the columns (row 0 captures w_data_in, row r captures row r-1).
// Ifmap rows stream in from the left with one cycle of skew per row and move one column right
// per cycle. Partial sums move one row down per cycle, so the bottom row of each column emits
// one dot product per ifmap vector.
//
// Ports:
//   clk              single clock, rising edge
//   rstn             asynchronous active-low reset
//   w_prefetch_in    one-cycle pulse that clears every weight register (wins over w_enable_in)
//   w_enable_in      weight shift enable
//   w_data_in        MAC_COL packed signed weights entering row 0 (lane c = column c)
//   ifmap_start_in   one-cycle pulse that clears the ifmap, enable and psum pipelines
//   ifmap_enable_in  per-row ifmap valid
//   ifmap_data_in    MAC_ROW packed signed ifmap elements (lane r = row r)
//   ofmap_valid_out  per-column result valid
//   ofmap_data_out   MAC_COL packed signed results
//
// Build option: define MACARRAY_SAT_EN to saturate each PE accumulation to the signed
// OFMAP_BITWIDTH range; otherwise accumulation wraps in two's complement.

module mac_array #(
    parameter int MAC_ROW        = 16,
    parameter int MAC_COL        = 16,
    parameter int IFMAP_BITWIDTH = 16,
    parameter int W_BITWIDTH     = 8,
    parameter int OFMAP_BITWIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              w_prefetch_in,
    input  logic                              w_enable_in,
    input  logic [MAC_COL*W_BITWIDTH-1:0]     w_data_in,
    input  logic                              ifmap_start_in,
    input  logic [MAC_ROW-1:0]                ifmap_enable_in,
    input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_in,
    output logic [MAC_COL-1:0]                ofmap_valid_out,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0] ofmap_data_out
);

    localparam int PROD_W = IFMAP_BITWIDTH + W_BITWIDTH;
`ifdef MACARRAY_SAT_EN
    // One guard bit so an overflowing step can be detected before clamping.
    localparam int SUM_W = OFMAP_BITWIDTH + 1;
    localparam logic signed [OFMAP_BITWIDTH-1:0] SAT_MAX = {1'b0, {(OFMAP_BITWIDTH-1){1'b1}}};
    localparam logic signed [OFMAP_BITWIDTH-1:0] SAT_MIN = {1'b1, {(OFMAP_BITWIDTH-1){1'b0}}};
`else
    localparam int SUM_W = OFMAP_BITWIDTH;
`endif

    logic signed [W_BITWIDTH-1:0]     weight_q [MAC_ROW][MAC_COL];
    logic signed [IFMAP_BITWIDTH-1:0] ifmap_q  [MAC_ROW][MAC_COL];
    logic                             en_q     [MAC_ROW][MAC_COL];
    logic signed [OFMAP_BITWIDTH-1:0] psum_q   [MAC_ROW][MAC_COL];

    logic signed [IFMAP_BITWIDTH-1:0] ifmap_d  [MAC_ROW][MAC_COL];
    logic                             en_d     [MAC_ROW][MAC_COL];
    logic signed [OFMAP_BITWIDTH-1:0] psum_d   [MAC_ROW][MAC_COL];

    // Weight shift chain; the prefetch clear takes priority over a same-cycle shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    weight_q[r][c] <= '0;
                end
            end
        end else if (w_prefetch_in) begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    weight_q[r][c] <= '0;
                end
            end
        end else if (w_enable_in) begin
            for (int c = 0; c < MAC_COL; c++) begin
                weight_q[0][c] <= w_data_in[c*W_BITWIDTH +: W_BITWIDTH];
                for (int r = 1; r < MAC_ROW; r++) begin
                    weight_q[r][c] <= weight_q[r-1][c];
                end
            end
        end
    end

    // PE next-state: forward ifmap/enable rightwards, accumulate psum downwards.
    always_comb begin
        logic signed [IFMAP_BITWIDTH-1:0] x_in;
        logic                             e_in;
        logic signed [OFMAP_BITWIDTH-1:0] p_in;
        logic signed [PROD_W-1:0]         prod;
        logic signed [SUM_W-1:0]          sum;
        x_in = '0;
        e_in = 1'b0;
        p_in = '0;
        prod = '0;
        sum  = '0;
        for (int r = 0; r < MAC_ROW; r++) begin
            for (int c = 0; c < MAC_COL; c++) begin
                if (c == 0) begin
                    x_in = ifmap_data_in[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH];
                    e_in = ifmap_enable_in[r];
                end else begin
                    x_in = ifmap_q[r][c-1];
                    e_in = en_q[r][c-1];
                end
                if (r == 0) begin
                    p_in = '0;
                end else begin
                    p_in = psum_q[r-1][c];
                end
                // Full-precision signed product, sign-extended into the accumulator width.
                prod = PROD_W'(x_in) * PROD_W'(weight_q[r][c]);
                sum  = SUM_W'(p_in) + SUM_W'(prod);

                ifmap_d[r][c] = x_in;
                en_d[r][c]    = e_in;
                if (!e_in) begin
                    psum_d[r][c] = p_in;
                end else begin
`ifdef MACARRAY_SAT_EN
                    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
                        psum_d[r][c] = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
                    end else begin
                        psum_d[r][c] = sum[OFMAP_BITWIDTH-1:0];
                    end
`else
                    psum_d[r][c] = sum;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    ifmap_q[r][c] <= '0;
                    en_q[r][c]    <= 1'b0;
                    psum_q[r][c]  <= '0;
                end
            end
        end else if (ifmap_start_in) begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    ifmap_q[r][c] <= '0;
                    en_q[r][c]    <= 1'b0;
                    psum_q[r][c]  <= '0;
                end
            end
        end else begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    ifmap_q[r][c] <= ifmap_d[r][c];
                    en_q[r][c]    <= en_d[r][c];
                    psum_q[r][c]  <= psum_d[r][c];
                end
            end
        end
    end

    always_comb begin
        ofmap_valid_out = '0;
        ofmap_data_out  = '0;
        for (int c = 0; c < MAC_COL; c++) begin
            ofmap_valid_out[c] = en_q[MAC_ROW-1][c];
            ofmap_data_out[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] = psum_q[MAC_ROW-1][c];
        end
    end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: self-checking bench for mac_array. A second instance with a 24-bit
// accumulator shares every input so that accumulator overflow is reachable.

module tb_mac_array;

    localparam int R    = 16;
    localparam int C    = 16;
    localparam int IW   = 16;
    localparam int WW   = 8;
    localparam int OW   = 32;
    localparam int NW   = 24;
    localparam int MAXV = 128;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              w_prefetch_in = 1'b0;
    logic              w_enable_in = 1'b0;
    logic [C*WW-1:0]   w_data_in = '0;
    logic              ifmap_start_in = 1'b0;
    logic [R-1:0]      ifmap_enable_in = '0;
    logic [R*IW-1:0]   ifmap_data_in = '0;
    logic [C-1:0]      ofmap_valid;
    logic [C*OW-1:0]   ofmap_data;
    logic [C-1:0]      ofmap_valid_n;
    logic [C*NW-1:0]   ofmap_data_n;

    always #5 clk = ~clk;

    mac_array #(
        .MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .OFMAP_BITWIDTH(OW)
    ) dut (
        .clk(clk), .rstn(rstn), .w_prefetch_in(w_prefetch_in), .w_enable_in(w_enable_in),
        .w_data_in(w_data_in), .ifmap_start_in(ifmap_start_in),
        .ifmap_enable_in(ifmap_enable_in), .ifmap_data_in(ifmap_data_in),
        .ofmap_valid_out(ofmap_valid), .ofmap_data_out(ofmap_data)
    );

    mac_array #(
        .MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .OFMAP_BITWIDTH(NW)
    ) dut_n (
        .clk(clk), .rstn(rstn), .w_prefetch_in(w_prefetch_in), .w_enable_in(w_enable_in),
        .w_data_in(w_data_in), .ifmap_start_in(ifmap_start_in),
        .ifmap_enable_in(ifmap_enable_in), .ifmap_data_in(ifmap_data_in),
        .ofmap_valid_out(ofmap_valid_n), .ofmap_data_out(ofmap_data_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;
    bit mon_on   = 1'b0;

    // Reference state: wm[r][c] is the weight meant for PE(r,c), xm[r][n] is ifmap[r][n].
    int wm [R][C];
    int xm [R][MAXV];
    int sched [MAXV];
    int e_edge [MAXV];

    logic signed [OW-1:0] ov  [C][$];
    int                   oe  [C][$];
    logic signed [NW-1:0] onv [C][$];

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int c = 0; c < C; c++) begin
                if (ofmap_valid[c]) begin
                    ov[c].push_back(ofmap_data[c*OW +: OW]);
                    oe[c].push_back(ecnt);
                end
                if (ofmap_valid_n[c]) onv[c].push_back(ofmap_data_n[c*NW +: NW]);
            end
        end
    end

    // Dot product of vector n with column c, accumulated row by row in a width-bit register.
    function automatic longint ref_dot(input int c, input int n, input int width);
        longint acc = 0;
        longint hi  = (longint'(1) << (width - 1)) - 1;
`ifdef MACARRAY_SAT_EN
        longint lo  = -(longint'(1) << (width - 1));
`endif
        for (int r = 0; r < R; r++) begin
            acc = acc + longint'(xm[r][n]) * longint'(wm[r][c]);
`ifdef MACARRAY_SAT_EN
            if (acc > hi) acc = hi;
            else if (acc < lo) acc = lo;
`else
            acc = acc & ((longint'(1) << width) - 1);
            if (acc > hi) acc = acc - (longint'(1) << width);
`endif
        end
        return acc;
    endfunction

    task automatic rand_weights();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(255)) - 128;
    endtask

    task automatic rand_ifmap();
        for (int r = 0; r < R; r++)
            for (int n = 0; n < MAXV; n++) xm[r][n] = int'($urandom_range(65535)) - 32768;
    endtask

    // Prefetch (with a junk shift on the same cycle) followed by R shifts, bottom row first.
    task automatic load_weights();
        w_prefetch_in = 1'b1;
        w_enable_in   = 1'b1;
        w_data_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
        w_prefetch_in = 1'b0;
        for (int k = 0; k < R; k++) begin
            for (int c = 0; c < C; c++) w_data_in[c*WW +: WW] = WW'(wm[R-1-k][c]);
            @(posedge clk); #1;
        end
        w_enable_in = 1'b0;
        w_data_in   = '0;
    endtask

    // Streams nv vectors with skewed rows and an optional row-0 enable gap, then scores every
    // column: result count, values (both widths) and the edge each result was registered on.
    task automatic run_stream(input string name, input int nv, input int gap_at,
                              input int gap_len);
        int steps;
        int idx;
        int tt;
        longint ex;
        steps = nv + gap_len;
        idx   = 0;
        for (int t = 0; t < steps; t++) begin
            if (gap_len > 0 && t >= gap_at && t < gap_at + gap_len) begin
                sched[t] = -1;
            end else begin
                sched[t] = idx;
                idx++;
            end
        end
        mon_on          = 1'b0;
        ifmap_enable_in = '0;
        ifmap_start_in  = 1'b1;
        @(posedge clk); #1;
        ifmap_start_in = 1'b0;
        for (int c = 0; c < C; c++) begin
            ov[c].delete();
            oe[c].delete();
            onv[c].delete();
        end
        mon_on = 1'b1;
        for (int t = 0; t < steps + R - 1; t++) begin
            for (int r = 0; r < R; r++) begin
                tt = t - r;
                if (tt >= 0 && tt < steps && sched[tt] >= 0) begin
                    ifmap_enable_in[r]         = 1'b1;
                    ifmap_data_in[r*IW +: IW]  = IW'(xm[r][sched[tt]]);
                    if (r == 0) e_edge[sched[tt]] = ecnt + 1;
                end else begin
                    ifmap_enable_in[r]         = 1'b0;
                    ifmap_data_in[r*IW +: IW]  = IW'($urandom());
                end
            end
            @(posedge clk); #1;
        end
        ifmap_enable_in = '0;
        repeat (R + C + 2) @(posedge clk);
        #1;
        mon_on = 1'b0;
        for (int c = 0; c < C; c++) begin
            n_checks++;
            if (ov[c].size() != nv || onv[c].size() != nv) begin
                n_fail++;
                $display("FAIL %s valid_count col=%0d got=%0d/%0d exp=%0d", name, c,
                         ov[c].size(), onv[c].size(), nv);
            end
            for (int n = 0; n < nv && n < ov[c].size() && n < onv[c].size(); n++) begin
                ex = ref_dot(c, n, OW);
                n_checks++;
                if (ov[c][n] !== OW'(ex)) begin
                    n_fail++;
                    $display("FAIL %s data col=%0d vec=%0d got=%0d exp=%0d", name, c, n,
                             ov[c][n], OW'(ex));
                end
                ex = ref_dot(c, n, NW);
                n_checks++;
                if (onv[c][n] !== NW'(ex)) begin
                    n_fail++;
                    $display("FAIL %s data24 col=%0d vec=%0d got=%0d exp=%0d", name, c, n,
                             onv[c][n], NW'(ex));
                end
                n_checks++;
                if (oe[c][n] != e_edge[n] + R - 1 + c) begin
                    n_fail++;
                    $display("FAIL %s latency col=%0d vec=%0d got_edge=%0d exp_edge=%0d", name,
                             c, n, oe[c][n], e_edge[n] + R - 1 + c);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (ofmap_valid !== '0 || ofmap_valid_n !== '0) begin
                n_fail++;
                $display("FAIL reset_valid cyc=%0d got=%h/%h exp=0", k, ofmap_valid,
                         ofmap_valid_n);
            end
            n_checks++;
            if (ofmap_data !== '0 || ofmap_data_n !== '0) begin
                n_fail++;
                $display("FAIL reset_data cyc=%0d got_nonzero exp=0", k);
            end
            @(posedge clk); #1;
            if (k == 1) rstn = 1'b1;
        end
    endtask

    task automatic test_identity();
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) wm[r][c] = (r == c) ? 1 : 0;
            for (int n = 0; n < 100; n++) xm[r][n] = 16 * n + r;
        end
        load_weights();
        run_stream("identity", 100, 0, 0);
        for (int c = 0; c < C; c++) begin
            n_checks++;
            if (oe[c].size() == 0 || oe[c][0] - e_edge[0] != R - 1 + c) begin
                n_fail++;
                $display("FAIL identity first_valid col=%0d got_delay=%0d exp=%0d", c,
                         (oe[c].size() == 0) ? -1 : oe[c][0] - e_edge[0], R - 1 + c);
            end
            for (int n = 0; n < 100 && n < ov[c].size(); n++) begin
                n_checks++;
                if (ov[c][n] !== OW'(16 * n + c)) begin
                    n_fail++;
                    $display("FAIL identity value col=%0d vec=%0d got=%0d exp=%0d", c, n,
                             ov[c][n], 16 * n + c);
                end
            end
        end
    endtask

    task automatic test_random();
        rand_weights();
        rand_ifmap();
        load_weights();
        run_stream("random", 100, 0, 0);
    endtask

    task automatic test_extremes();
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) wm[r][c] = -128;
            for (int n = 0; n < 8; n++) xm[r][n] = -32768;
        end
        load_weights();
        run_stream("extremes", 8, 0, 0);
        for (int c = 0; c < C; c++) begin
            for (int n = 0; n < 8 && n < ov[c].size(); n++) begin
                n_checks++;
                if (ov[c][n] !== 32'sd67108864) begin
                    n_fail++;
                    $display("FAIL extremes col=%0d vec=%0d got=%0d exp=67108864", c, n,
                             ov[c][n]);
                end
            end
        end
    endtask

    // Narrow instance: 4194304 + 4 stays in range, then + 4194304 lands 5 above 2^23-1.
    task automatic test_overflow();
        logic signed [NW-1:0] exp_n;
`ifdef MACARRAY_SAT_EN
        exp_n = 24'sh7FFFFF;
`else
        exp_n = -24'sd8388604;
`endif
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wm[r][c] = 0;
        rand_ifmap();
        for (int c = 0; c < C; c++) begin
            wm[0][c]   = -128;
            wm[1][c]   = 4;
            wm[R-1][c] = -128;
        end
        for (int n = 0; n < 4; n++) begin
            xm[0][n]   = -32768;
            xm[1][n]   = 1;
            xm[R-1][n] = -32768;
        end
        load_weights();
        run_stream("overflow", 4, 0, 0);
        for (int c = 0; c < C; c++) begin
            for (int n = 0; n < 4 && n < onv[c].size() && n < ov[c].size(); n++) begin
                n_checks++;
                if (onv[c][n] !== exp_n || ov[c][n] !== 32'sd8388612) begin
                    n_fail++;
                    $display("FAIL overflow col=%0d vec=%0d got=%0d/%0d exp=%0d/8388612", c, n,
                             onv[c][n], ov[c][n], exp_n);
                end
            end
        end
    endtask

    task automatic test_gap();
        rand_weights();
        rand_ifmap();
        load_weights();
        run_stream("gap", 40, 17, 3);
        for (int c = 0; c < C; c++) begin
            if (oe[c].size() >= 18) begin
                n_checks++;
                if (oe[c][17] - oe[c][16] != 4 || oe[c][16] - oe[c][15] != 1) begin
                    n_fail++;
                    $display("FAIL gap spacing col=%0d got=%0d,%0d exp=1,4", c,
                             oe[c][16] - oe[c][15], oe[c][17] - oe[c][16]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_weights();
        rand_ifmap();
        load_weights();
        ifmap_start_in = 1'b1;
        @(posedge clk); #1;
        ifmap_start_in = 1'b0;
        for (int t = 0; t < 10; t++) begin
            ifmap_enable_in = '1;
            for (int r = 0; r < R; r++) ifmap_data_in[r*IW +: IW] = IW'(xm[r][t]);
            @(posedge clk); #1;
        end
        rstn            = 1'b0;
        ifmap_enable_in = '0;
        for (int k = 0; k < R + C + 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (ofmap_valid !== '0 || ofmap_data !== '0 || ofmap_valid_n !== '0) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got_valid=%h exp_valid=0 exp_data=0", k,
                         ofmap_valid);
            end
            @(posedge clk); #1;
            if (k == 1) rstn = 1'b1;
        end
        // Reset also cleared the weights.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wm[r][c] = 0;
        run_stream("post_reset", 10, 0, 0);
    endtask

    task automatic test_prefetch_clear();
        rand_weights();
        rand_ifmap();
        load_weights();
        w_prefetch_in = 1'b1;
        w_enable_in   = 1'b1;
        w_data_in     = {C{8'h55}};
        @(posedge clk); #1;
        w_prefetch_in = 1'b0;
        w_enable_in   = 1'b0;
        w_data_in     = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wm[r][c] = 0;
        run_stream("prefetch_clear", 20, 0, 0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_random();
        test_extremes();
        test_overflow();
        test_gap();
        test_reset_mid();
        test_prefetch_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
